// File: rtl/tl_pkg.sv
// Shared phase encoding and default durations for the crosswalk phase scheduler.
package tl_pkg;

  typedef enum logic [2:0] {
    N_GRN    = 3'd0,
    N_YLW    = 3'd1,
    N_CLR    = 3'd2,
    W_GRN    = 3'd3,
    W_YLW    = 3'd4,
    W_CLR    = 3'd5,
    WALK     = 3'd6,
    WALK_CLR = 3'd7
  } phase_t;

  localparam int GRN_SEC_DEF     = 8;
  localparam int MIN_GRN_SEC_DEF = 3;
  localparam int YLW_SEC_DEF     = 3;
  localparam int CLR_SEC_DEF     = 1;
  localparam int WALK_SEC_DEF    = 5;

endpackage

// File: rtl/phase_timer.sv
// Tick-enabled 4-bit duration counter; done flags the tick that completes DUR ticks.
module phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       clr,
  input  logic [3:0] dur,
  output logic [3:0] cnt,
  output logic       done
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (tick) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign done = tick && (cnt == dur - 4'd1);

endmodule

// File: rtl/xwalk_phase_scheduler.sv
// Two-way intersection phase FSM with a shared pedestrian walk phase and
// round-robin arbitration between north and west walk requests.
module xwalk_phase_scheduler
  import tl_pkg::*;
#(
  parameter int GRN_SEC     = GRN_SEC_DEF,
  parameter int MIN_GRN_SEC = MIN_GRN_SEC_DEF,
  parameter int YLW_SEC     = YLW_SEC_DEF,
  parameter int CLR_SEC     = CLR_SEC_DEF,
  parameter int WALK_SEC    = WALK_SEC_DEF
) (
  input  logic       clk_50_mhz,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       nrth_req,
  input  logic       west_req,
  output logic       grn_nrth,
  output logic       ylw_nrth,
  output logic       red_nrth,
  output logic       grn_west,
  output logic       ylw_west,
  output logic       red_west,
  output logic       walk_nrth,
  output logic       stop_nrth,
  output logic       walk_west,
  output logic       stop_west,
  output logic       pend_nrth,
  output logic       pend_west,
  output logic [2:0] phase
);

  phase_t     state, state_nx, ret_grn;
  logic [3:0] dur, cnt;
  logic       done, clr;
  logic       rr_west, gnt_west, gnt_west_nx;
  logic       pend_any, enter_walk, take_nrth, take_west, walk_n_nx, walk_w_nx;

  always_comb begin
    dur = 4'(CLR_SEC);
    case (state)
      N_GRN, W_GRN: dur = 4'(GRN_SEC);
      N_YLW, W_YLW: dur = 4'(YLW_SEC);
      WALK:         dur = 4'(WALK_SEC);
      default:      dur = 4'(CLR_SEC);
    endcase
  end

  phase_timer u_timer (
    .clk   (clk_50_mhz),
    .reset (reset),
    .tick  (tick_1hz),
    .clr   (clr),
    .dur   (dur),
    .cnt   (cnt),
    .done  (done)
  );

  assign pend_any = pend_nrth | pend_west;

  // A pending request may cut green short once the minimum green has elapsed.
  always_comb begin
    state_nx = state;
    case (state)
      N_GRN:    if (done || (tick_1hz && pend_any && cnt >= 4'(MIN_GRN_SEC - 1))) state_nx = N_YLW;
      N_YLW:    if (done) state_nx = N_CLR;
      N_CLR:    if (done) state_nx = pend_any ? WALK : W_GRN;
      W_GRN:    if (done || (tick_1hz && pend_any && cnt >= 4'(MIN_GRN_SEC - 1))) state_nx = W_YLW;
      W_YLW:    if (done) state_nx = W_CLR;
      W_CLR:    if (done) state_nx = pend_any ? WALK : N_GRN;
      WALK:     if (done) state_nx = WALK_CLR;
      WALK_CLR: if (done) state_nx = ret_grn;
      default:  state_nx = N_GRN;
    endcase
  end

  assign clr         = (state_nx != state);
  assign enter_walk  = (state_nx == WALK) && (state != WALK);
  assign gnt_west_nx = pend_west && (!pend_nrth || rr_west);
  assign take_nrth   = enter_walk && !gnt_west_nx;
  assign take_west   = enter_walk && gnt_west_nx;
  assign walk_n_nx   = (state_nx == WALK) && !(enter_walk ? gnt_west_nx : gnt_west);
  assign walk_w_nx   = (state_nx == WALK) &&  (enter_walk ? gnt_west_nx : gnt_west);

  always_ff @(posedge clk_50_mhz or posedge reset) begin
    if (reset) begin
      state     <= N_GRN;
      ret_grn   <= N_GRN;
      rr_west   <= 1'b0;
      gnt_west  <= 1'b0;
      pend_nrth <= 1'b0;
      pend_west <= 1'b0;
      grn_nrth  <= 1'b1;
      ylw_nrth  <= 1'b0;
      red_nrth  <= 1'b0;
      grn_west  <= 1'b0;
      ylw_west  <= 1'b0;
      red_west  <= 1'b1;
      walk_nrth <= 1'b0;
      stop_nrth <= 1'b1;
      walk_west <= 1'b0;
      stop_west <= 1'b1;
    end else begin
      state <= state_nx;
      if (enter_walk) begin
        gnt_west <= gnt_west_nx;
        ret_grn  <= (state == N_CLR) ? W_GRN : N_GRN;
        if (pend_nrth && pend_west) rr_west <= ~rr_west;
      end
      // Grant clear wins over a same-edge request; own walk blocks re-latching.
      if (take_nrth)                   pend_nrth <= 1'b0;
      else if (nrth_req && !walk_nrth) pend_nrth <= 1'b1;
      if (take_west)                   pend_west <= 1'b0;
      else if (west_req && !walk_west) pend_west <= 1'b1;
      grn_nrth  <= (state_nx == N_GRN);
      ylw_nrth  <= (state_nx == N_YLW);
      red_nrth  <= !((state_nx == N_GRN) || (state_nx == N_YLW));
      grn_west  <= (state_nx == W_GRN);
      ylw_west  <= (state_nx == W_YLW);
      red_west  <= !((state_nx == W_GRN) || (state_nx == W_YLW));
      walk_nrth <= walk_n_nx;
      stop_nrth <= !walk_n_nx;
      walk_west <= walk_w_nx;
      stop_west <= !walk_w_nx;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_xwalk_phase_scheduler.sv
// Directed bench for the crosswalk phase scheduler at default durations.
module tb_xwalk_phase_scheduler;

  logic       clk_50_mhz, reset, tick_1hz, nrth_req, west_req;
  logic       grn_nrth, ylw_nrth, red_nrth, grn_west, ylw_west, red_west;
  logic       walk_nrth, stop_nrth, walk_west, stop_west, pend_nrth, pend_west;
  logic [2:0] phase;

  int compared   = 0;
  int mismatched = 0;

  xwalk_phase_scheduler dut (
    .clk_50_mhz (clk_50_mhz),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .nrth_req   (nrth_req),
    .west_req   (west_req),
    .grn_nrth   (grn_nrth),
    .ylw_nrth   (ylw_nrth),
    .red_nrth   (red_nrth),
    .grn_west   (grn_west),
    .ylw_west   (ylw_west),
    .red_west   (red_west),
    .walk_nrth  (walk_nrth),
    .stop_nrth  (stop_nrth),
    .walk_west  (walk_west),
    .stop_west  (stop_west),
    .pend_nrth  (pend_nrth),
    .pend_west  (pend_west),
    .phase      (phase)
  );

  initial clk_50_mhz = 1'b0;
  always #5 clk_50_mhz = ~clk_50_mhz;

  task automatic cyc();
    @(posedge clk_50_mhz);
    #1;
  endtask

  // One tick edge followed by per-1 idle cycles.
  task automatic tick_step(input int per);
    tick_1hz = 1'b1;
    cyc();
    if (per > 1) begin
      tick_1hz = 1'b0;
      repeat (per - 1) cyc();
    end
  endtask

  // Number of tick steps until phase changes (bounded at 40).
  task automatic run_phase(input int per, output int n);
    logic [2:0] start;
    start = phase;
    n = 0;
    while (phase == start && n < 40) begin
      tick_step(per);
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick_1hz = 1'b0;
    nrth_req = 1'b0;
    west_req = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    #3;
    obs = {grn_nrth, ylw_nrth, red_nrth, grn_west, ylw_west, red_west,
           walk_nrth, stop_nrth, walk_west, stop_west, pend_nrth, pend_west};
    compared++;
    if (obs !== 12'b100_001_01_01_00) begin
      mismatched++;
      $display("FAIL reset_outputs got %b want %b", obs, 12'b100_001_01_01_00);
    end
    compared++;
    if (phase !== 3'd0) begin
      mismatched++;
      $display("FAIL reset_phase got %0d want 0", phase);
    end
    do_reset();
  endtask

  task automatic test_no_req();
    int exp_ph[6] = '{1, 2, 3, 4, 5, 0};
    int exp_n[6]  = '{8, 3, 1, 8, 3, 1};
    int n;
    for (int i = 0; i < 6; i++) begin
      run_phase(4, n);
      compared++;
      if (n !== exp_n[i]) begin
        mismatched++;
        $display("FAIL no_req_ticks[%0d] got %0d want %0d", i, n, exp_n[i]);
      end
      compared++;
      if (phase !== 3'(exp_ph[i])) begin
        mismatched++;
        $display("FAIL no_req_phase[%0d] got %0d want %0d", i, phase, exp_ph[i]);
      end
    end
  endtask

  task automatic test_north_req();
    int exp_ph[5] = '{1, 2, 6, 7, 3};
    int exp_n[5]  = '{2, 3, 1, 5, 1};
    int n;
    do_reset();
    nrth_req = 1'b1;
    tick_step(4);
    nrth_req = 1'b0;
    compared++;
    if (pend_nrth !== 1'b1) begin
      mismatched++;
      $display("FAIL north_pend_set got %b want 1", pend_nrth);
    end
    for (int i = 0; i < 5; i++) begin
      run_phase(4, n);
      compared++;
      if (n !== exp_n[i] || phase !== 3'(exp_ph[i])) begin
        mismatched++;
        $display("FAIL north_seq[%0d] got ticks %0d phase %0d want ticks %0d phase %0d",
                 i, n, phase, exp_n[i], exp_ph[i]);
      end
      if (phase == 3'd6) begin
        compared++;
        if ({walk_nrth, stop_nrth, walk_west, stop_west, pend_nrth} !== 5'b10010) begin
          mismatched++;
          $display("FAIL north_walk_entry got %b want 10010",
                   {walk_nrth, stop_nrth, walk_west, stop_west, pend_nrth});
        end
      end
    end
  endtask

  task automatic test_both_req();
    int exp_ph[10] = '{4, 5, 6, 7, 0, 1, 2, 6, 7, 3};
    int exp_n[10]  = '{2, 3, 1, 5, 1, 3, 3, 1, 5, 1};
    int n;
    nrth_req = 1'b1;
    west_req = 1'b1;
    tick_step(4);
    nrth_req = 1'b0;
    west_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run_phase(4, n);
      compared++;
      if (n !== exp_n[i] || phase !== 3'(exp_ph[i])) begin
        mismatched++;
        $display("FAIL both_seq[%0d] got ticks %0d phase %0d want ticks %0d phase %0d",
                 i, n, phase, exp_n[i], exp_ph[i]);
      end
      if (i == 2 || i == 7) begin
        compared++;
        if ({walk_nrth, walk_west, pend_nrth, pend_west} !== ((i == 2) ? 4'b1001 : 4'b0100)) begin
          mismatched++;
          $display("FAIL both_walk[%0d] got %b want %b", i,
                   {walk_nrth, walk_west, pend_nrth, pend_west},
                   (i == 2) ? 4'b1001 : 4'b0100);
        end
      end
    end
  endtask

  task automatic test_reset_mid_walk();
    int n;
    logic [11:0] obs;
    do_reset();
    nrth_req = 1'b1;
    tick_step(4);
    nrth_req = 1'b0;
    repeat (3) run_phase(4, n);
    compared++;
    if (phase !== 3'd6 || walk_nrth !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_walk_reach got phase %0d walk %b want phase 6 walk 1", phase, walk_nrth);
    end
    west_req = 1'b1;
    tick_step(4);
    west_req = 1'b0;
    compared++;
    if (pend_west !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_pend_west_before got %b want 1", pend_west);
    end
    @(posedge clk_50_mhz);
    #3;
    reset = 1'b1;
    #1;
    obs = {grn_nrth, ylw_nrth, red_nrth, grn_west, ylw_west, red_west,
           walk_nrth, stop_nrth, walk_west, stop_west, pend_nrth, pend_west};
    compared++;
    if (obs !== 12'b100_001_01_01_00 || phase !== 3'd0) begin
      mismatched++;
      $display("FAIL rst_async got %b phase %0d want 100001010100 phase 0", obs, phase);
    end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_tick_continuous();
    int exp_ph[6] = '{1, 2, 3, 4, 5, 0};
    int exp_n[6]  = '{8, 3, 1, 8, 3, 1};
    int n;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_phase(1, n);
      compared++;
      if (n !== exp_n[i] || phase !== 3'(exp_ph[i])) begin
        mismatched++;
        $display("FAIL cont_seq[%0d] got cycles %0d phase %0d want cycles %0d phase %0d",
                 i, n, phase, exp_n[i], exp_ph[i]);
      end
    end
    tick_1hz = 1'b0;
  endtask

  task automatic test_req_held();
    logic ok, saw_walk, saw_exit;
    saw_walk = 1'b0;
    saw_exit = 1'b0;
    do_reset();
    nrth_req = 1'b1;
    for (int i = 0; i < 160; i++) begin
      tick_1hz = (i % 4 == 0);
      cyc();
      ok = (int'(grn_nrth) + int'(ylw_nrth) + int'(red_nrth) == 1) &&
           (int'(grn_west) + int'(ylw_west) + int'(red_west) == 1) &&
           !((grn_nrth | ylw_nrth) && (grn_west | ylw_west)) &&
           !((walk_nrth | walk_west) && (grn_nrth | ylw_nrth | grn_west | ylw_west)) &&
           (stop_nrth == !walk_nrth) && (stop_west == !walk_west);
      compared++;
      if (!ok) begin
        mismatched++;
        $display("FAIL held_invariant cycle %0d got lights %b want legal",
                 i, {grn_nrth, ylw_nrth, red_nrth, grn_west, ylw_west, red_west,
                     walk_nrth, stop_nrth, walk_west, stop_west});
      end
      if (phase == 3'd6) begin
        saw_walk = 1'b1;
        compared++;
        if (pend_nrth !== 1'b0 || walk_nrth !== 1'b1) begin
          mismatched++;
          $display("FAIL held_walk cycle %0d got pend %b walk %b want pend 0 walk 1",
                   i, pend_nrth, walk_nrth);
        end
      end
      if (saw_walk && phase == 3'd7) saw_exit = 1'b1;
    end
    tick_1hz = 1'b0;
    nrth_req = 1'b0;
    compared++;
    if ({saw_walk, saw_exit} !== 2'b11) begin
      mismatched++;
      $display("FAIL held_walk_seen got %b want 11", {saw_walk, saw_exit});
    end
  endtask

  initial begin
    reset = 1'b1;
    tick_1hz = 1'b0;
    nrth_req = 1'b0;
    west_req = 1'b0;
    test_reset();
    test_no_req();
    test_north_req();
    test_both_req();
    test_reset_mid_walk();
    test_tick_continuous();
    test_req_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/xwalk_phase_scheduler.md
XWALK_PHASE_SCHEDULER -- requirements
Module: xwalk_phase_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): GRN_SEC, 8, full green duration in ticks.
REQ-002 MIN_GRN_SEC, 3, minimum green before a pending walk request may cut green short.
REQ-003 YLW_SEC, 3, yellow duration in ticks.
REQ-004 CLR_SEC, 1, all-red clearance duration in ticks.
REQ-005 WALK_SEC, 5, pedestrian walk duration in ticks.
REQ-006 All durations SHALL be in the range 1..15, and MIN_GRN_SEC SHALL be less than or equal to GRN_SEC.
REQ-007 The block SHALL have these ports (name, direction, width, meaning):
- clk_50_mhz, in, 1, the only clock.
- reset, in, 1, asynchronous active-high reset.
- tick_1hz, in, 1, one-cycle timing enable.
- nrth_req, in, 1, debounced north pedestrian request (level).
- west_req, in, 1, debounced west pedestrian request (level).
- grn_nrth / ylw_nrth / red_nrth, out, 1 each, north vehicle heads.
- grn_west / ylw_west / red_west, out, 1 each, west vehicle heads.
- walk_nrth / stop_nrth, out, 1 each, north pedestrian heads.
- walk_west / stop_west, out, 1 each, west pedestrian heads.
- pend_nrth / pend_west, out, 1 each, latched requests awaiting service.
- phase, out, 3, current state code.

Function
REQ-008 The state machine SHALL have these states and phase codes: N_GRN=0, N_YLW=1, N_CLR=2, W_GRN=3, W_YLW=4, W_CLR=5, WALK=6, WALK_CLR=7.
REQ-009 A 4-bit duration counter SHALL increment only on clock edges where tick_1hz=1.
- It SHALL clear to 0 on every state transition.
- A state SHALL exit on the edge where tick_1hz=1 and the counter equals DUR-1; all state changes occur only on tick edges.
REQ-010 N_GRN SHALL go to N_YLW when either:
- the counter reaches GRN_SEC-1, or
- (pend_nrth|pend_west)=1 and the counter is at or above MIN_GRN_SEC-1.
W_GRN SHALL go to W_YLW on the same rule.
REQ-011 Yellow and clearance sequencing SHALL be:
- N_YLW -> N_CLR after YLW_SEC ticks.
- W_YLW -> W_CLR after YLW_SEC ticks.
- The CLR states last CLR_SEC ticks.
REQ-012 On exit from N_CLR, the block SHALL go to WALK if any request is pending, else to W_GRN. On exit from W_CLR, it SHALL go to WALK if any request is pending, else to N_GRN.
REQ-013 On entering WALK, the block SHALL record the return green: W_GRN if entered from N_CLR, N_GRN if entered from W_CLR. WALK lasts WALK_SEC ticks, then WALK_CLR lasts CLR_SEC ticks, then the block goes to the recorded return green.
REQ-014 Arbitration on entry to WALK SHALL work as follows:
- If exactly one request is pending, grant it.
- If both are pending, grant the direction named by a round-robin pointer, then toggle the pointer.
- The ungranted request stays pending.
REQ-015 Each pending flag SHALL behave as follows:
- It is set on any edge where its req=1.
- It is not set while its own walk output is 1.
- It is cleared on the edge its grant is taken; the clear wins over a simultaneous set.
REQ-016 Outputs SHALL be registered, decoded from the next state, and therefore valid in the same cycle as the state register.
REQ-017 Output decode SHALL be:
- grn/ylw for a direction are high only in that direction's GRN/YLW state, and red is high otherwise.
- walk_x is high only in WALK for the granted direction.
- stop_x = ~walk_x.
- Exactly one of grn/ylw/red is high per direction at all times.
REQ-018 The block SHALL never assert grn or ylw of both directions at once, and SHALL never assert any walk while any grn/ylw is high.

Reset
REQ-019 While reset=1, asynchronously and independent of the clock, the block SHALL hold:
- state=N_GRN, counter=0, pend_nrth=pend_west=0.
- round-robin pointer=north, return green=N_GRN.
- grn_nrth=1, red_west=1, stop_nrth=stop_west=1, and every other light output 0.
REQ-020 A reset asserted mid-phase, including during WALK, SHALL abandon the phase and any pending grant without a yellow or clearance interval.

Structure
REQ-021 A shared package tl_pkg SHALL hold the phase encoding enum/localparams and the default duration constants.
REQ-022 One sub-module, phase_timer, SHALL implement the tick-enabled 4-bit counter with clear and a done(DUR) compare; the FSM, arbiter and output decode SHALL stay in xwalk_phase_scheduler.

Verification
REQ-023 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- Defaults, tick every 4 cycles, no requests -> phase sequence 0,1,2,3,4,5,0 with 8/3/1/8/3/1 ticks per state (24 ticks per cycle).
- nrth_req pulse at tick 1 of N_GRN -> N_YLW after tick 3, then N_CLR, then WALK with walk_nrth=1 for 5 ticks, then WALK_CLR for 1 tick, then W_GRN; pend_nrth falls on WALK entry.
- nrth_req and west_req high together in W_GRN -> first WALK serves north and returns to N_GRN; N_GRN ends after 3 ticks; the next WALK serves west.
- reset asserted mid-WALK between clock edges -> walk outputs drop, grn_nrth=1 and pend flags 0 immediately, with no clock edge needed.
- tick_1hz held at 1 continuously -> every state lasts exactly DUR cycles.
- nrth_req held high throughout its own WALK -> pend_nrth stays 0 until WALK exits, and the invariants of REQ-017 and REQ-018 hold every cycle.
